trng_entropy_collector: RTL and testbench

- Consumes the 1-bit entropy outputs of two free-running oscillator sources, for example a Fibonacci and a Galois ring oscillator.
- Synchronises both inputs, XORs them and decimates them at a programmable sample rate. Packs the sampled bits into 32-bit words.
- Hands each word to the TRNG core register interface with a valid/ack handshake.
- Runs a repetition-count health test. A stuck source blocks all output until reset.

---
 rtl/trng_pkg.sv | 11 +
 rtl/trng_sync2.sv | 10 +
 rtl/trng_entropy_collector.sv | 72 +++++++
 tb/tb_trng_entropy_collector.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/trng_pkg.sv
// trng_pkg: shared controller state encodings, word width and register defaults for the TRNG.
package trng_pkg;
    typedef enum logic [1:0] {
        CTRL_IDLE    = 2'h0,
        CTRL_COLLECT = 2'h1,
        CTRL_ERROR   = 2'h2
    } ctrl_state_e;
    localparam int WORD_BITS = 32;
    localparam logic [15:0] DEF_SAMPLE_RATE = 16'd4096;
    localparam logic [7:0] DEF_REP_LIMIT = 8'd32;
endpackage

// File: rtl/trng_sync2.sv
// trng_sync2: two-flop synchroniser for an oscillator output asynchronous to clk.
module trng_sync2 (
    input  logic clk,
    input  logic d,
    output logic q
);
    (* keep = "true" *) logic [1:0] ff;
    always_ff @(posedge clk) ff <= {ff[0], d};
    assign q = ff[1];
endmodule

// File: rtl/trng_entropy_collector.sv
// trng_entropy_collector: XORs two synchronised oscillator bits, decimates them into 32-bit words
// and hands the words out with valid/ack; a repetition-count health test locks out a stuck source.
module trng_entropy_collector
    import trng_pkg::*;
#(
    parameter logic [15:0] SAMPLE_RATE = DEF_SAMPLE_RATE,
    parameter logic [7:0]  REP_LIMIT   = DEF_REP_LIMIT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 entropy0,
    input  logic                 entropy1,
    input  logic                 data_ack,
    output logic [WORD_BITS-1:0] data,
    output logic                 data_valid,
    output logic                 health_error
);
    ctrl_state_e state, state_next;
    logic [15:0] sample_ctr;
    logic [4:0] bit_ctr;
    logic [7:0] rep_ctr, rep_next;
    logic [WORD_BITS-1:0] shift, shift_next;
    logic last_s, e0_s, e1_s, s, active, sample, fail, load;

    trng_sync2 u_sync0 (.clk(clk), .d(entropy0), .q(e0_s));
    trng_sync2 u_sync1 (.clk(clk), .d(entropy1), .q(e1_s));

    // The cycle that leaves IDLE already counts, so the first word lands 32*SAMPLE_RATE cycles after enable.
    always_comb begin
        s = e0_s ^ e1_s;
        active = enable && state != CTRL_ERROR;
        sample = active && sample_ctr == SAMPLE_RATE - 16'd1;
        rep_next = (rep_ctr != 8'd0 && s == last_s) ? rep_ctr + 8'd1 : 8'd1;
        fail = sample && rep_next == REP_LIMIT;
        shift_next = {shift[WORD_BITS-2:0], s};
        load = sample && bit_ctr == 5'd31 && !fail && (!data_valid || data_ack);
        state_next = fail ? CTRL_ERROR : state == CTRL_ERROR ? CTRL_ERROR : enable ? CTRL_COLLECT : CTRL_IDLE;
        health_error = state == CTRL_ERROR;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CTRL_IDLE;
            sample_ctr <= '0;
            bit_ctr <= '0;
            rep_ctr <= '0;
            last_s <= 1'b0;
            shift <= '0;
            data <= '0;
            data_valid <= 1'b0;
        end else begin
            state <= state_next;
            if (!enable) begin
                sample_ctr <= '0;
                bit_ctr <= '0;
                rep_ctr <= '0;
                shift <= '0;
            end else if (active) begin
                sample_ctr <= sample ? 16'd0 : sample_ctr + 16'd1;
                if (sample) begin
                    shift <= shift_next;
                    bit_ctr <= bit_ctr + 5'd1;
                    rep_ctr <= rep_next;
                    last_s <= s;
                end
            end
            data_valid <= fail ? 1'b0 : load ? 1'b1 : data_ack ? 1'b0 : data_valid;
            if (load) data <= shift_next;
        end
    end
endmodule

// File: tb/tb_trng_entropy_collector.sv
// tb_trng_entropy_collector: directed latency/handshake/health scenarios plus random traffic,
// checked by a scoreboard fed from a sample-list reference model.
module tb_trng_entropy_collector;
    localparam int SR = 2;
    localparam int RL = 8;

    typedef struct {int tag; logic [31:0] w;} sb_t;

    logic clk = 1'b0, reset = 1'b1, enable = 1'b0, entropy0 = 1'b0, entropy1 = 1'b0, data_ack = 1'b0;
    logic [31:0] data;
    logic data_valid, health_error;

    int checks = 0, errors = 0, cyc = 0, run_cyc = 0;
    bit started = 0;
    bit xh[int];
    bit bits[$], hist[$];
    sb_t sb[$];
    logic m_valid = 0, m_err = 0;
    logic [31:0] m_data = 0;

    trng_entropy_collector #(.SAMPLE_RATE(16'd2), .REP_LIMIT(8'd8)) dut (
        .clk(clk), .reset(reset), .enable(enable), .entropy0(entropy0), .entropy1(entropy1),
        .data_ack(data_ack), .data(data), .data_valid(data_valid), .health_error(health_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string n, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", n, act, exp, cyc);
        end
    endfunction

    // Drives one cycle and advances the model to the state expected after the coming edge.
    task automatic step(input bit r, input bit en, input bit a0, input bit a1, input bit ack);
        int e;
        bit s, fail, done;
        logic [31:0] w;
        @(negedge clk);
        reset = r; enable = en; entropy0 = a0; entropy1 = a1; data_ack = ack;
        e = cyc;
        xh[e] = a0 ^ a1;
        started = 1;
        fail = 0; done = 0; w = '0;
        if (r) begin
            m_valid = 0; m_data = '0; m_err = 0;
            bits.delete(); hist.delete(); run_cyc = 0;
        end else if (!m_err) begin
            if (!en) begin
                bits.delete(); hist.delete(); run_cyc = 0;
            end else begin
                if (run_cyc % SR == SR - 1) begin
                    s = xh[e-2];
                    bits.push_back(s);
                    hist.push_back(s);
                    if (hist.size() > RL) void'(hist.pop_front());
                    fail = hist.size() == RL;
                    foreach (hist[i]) if (hist[i] != s) fail = 0;
                    if (bits.size() == 32) begin
                        foreach (bits[i]) w = {w[30:0], bits[i]};
                        bits.delete();
                        done = 1;
                    end
                end
                run_cyc++;
            end
            if (fail) begin
                m_err = 1; m_valid = 0;
            end else if (done && (!m_valid || ack)) begin
                m_valid = 1; m_data = w;
                sb.push_back('{cyc + 1, w});
            end else if (ack) m_valid = 0;
        end
        @(posedge clk);
        #2;
    endtask

    // Pattern bit for sample j is pat[3 - j%4], with samples at edges base+1, base+3, ...
    task automatic pat_run(input int n, input bit en, input logic [3:0] pat, input int base, input int ack_e);
        for (int i = 0; i < n; i++) begin
            int o;
            o = cyc - base + 1;
            if (o < 0) o = 0;
            step(0, en, pat[3 - (o / 2) % 4], 0, cyc == ack_e);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (started) begin
            chk("valid", data_valid, m_valid);
            chk("health", health_error, m_err);
            chk("data", data, m_data);
            if (sb.size() > 0 && sb[0].tag == cyc) begin
                sb_t it;
                it = sb.pop_front();
                chk("sb_word", {data_valid, data}, {1'b1, it.w});
            end
        end
    end

    initial begin
        int b;
        bit en;
        repeat (4) step(1, 0, 0, 0, 0);
        chk("rst_data", data, 0);
        chk("rst_valid", data_valid, 0);
        chk("rst_health", health_error, 0);

        b = cyc + 1;
        pat_run(1, 0, 4'b1010, b, -1);
        pat_run(63, 1, 4'b1010, b, -1);
        chk("lat63_valid", data_valid, 0);
        pat_run(1, 1, 4'b1010, b, -1);
        chk("lat64_valid", data_valid, 1);
        chk("lat64_data", data, 32'hAAAAAAAA);
        chk("lat64_health", health_error, 0);

        pat_run(66, 1, 4'b1010, b, -1);
        chk("hold_valid", data_valid, 1);
        chk("hold_data", data, 32'hAAAAAAAA);
        pat_run(1, 1, 4'b1010, b, b + 130);
        chk("ack_clear", data_valid, 0);

        pat_run(61, 1, 4'b1010, b, -1);
        chk("third_valid", data_valid, 1);
        pat_run(64, 1, 4'b1010, b, b + 255);
        chk("ack_reload_valid", data_valid, 1);
        chk("ack_reload_data", data, 32'hAAAAAAAA);
        pat_run(1, 1, 4'b1010, b, cyc);

        pat_run(3, 0, 4'b1010, b, -1);
        b = cyc + 1;
        pat_run(1, 0, 4'b1010, b, -1);
        pat_run(20, 1, 4'b1010, b, -1);
        pat_run(5, 0, 4'b1010, b, -1);
        b = cyc + 1;
        pat_run(1, 0, 4'b1100, b, -1);
        pat_run(63, 1, 4'b1100, b, -1);
        chk("reen63_valid", data_valid, 0);
        pat_run(1, 1, 4'b1100, b, -1);
        chk("reen_valid", data_valid, 1);
        chk("reen_data", data, 32'hCCCCCCCC);

        pat_run(10, 1, 4'b1100, b, -1);
        step(1, 0, 0, 0, 0);
        chk("midrst_data", data, 0);
        chk("midrst_valid", data_valid, 0);
        chk("midrst_health", health_error, 0);
        step(1, 0, 0, 0, 0);

        b = cyc + 1;
        pat_run(1, 0, 4'b0000, b, -1);
        pat_run(15, 1, 4'b0000, b, -1);
        chk("rep7_health", health_error, 0);
        pat_run(1, 1, 4'b0000, b, -1);
        chk("rep8_health", health_error, 1);
        chk("rep8_valid", data_valid, 0);
        pat_run(3, 0, 4'b0000, b, -1);
        pat_run(3, 1, 4'b0000, b, -1);
        chk("sticky_health", health_error, 1);
        step(1, 0, 0, 0, 0);
        chk("clr_health", health_error, 0);
        step(1, 0, 0, 0, 0);

        en = 1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(149) == 0) en = !en;
            step($urandom_range(399) == 0, en, 1'($urandom), 1'($urandom), $urandom_range(7) == 0);
        end
        repeat (2) step(0, 0, 0, 0, 0);
        chk("sb_drain", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
